flopr: RTL and testbench

FLOPR -- requirements
Module: flopr

---
 rtl/flopr_pkg.sv | 12 +
 rtl/flopr_stage.sv | 22 ++
 rtl/flopr.sv | 47 ++++
 tb/tb_flopr.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/flopr_pkg.sv
// Shared defaults and legal parameter ranges for the flopr register chain.
package flopr_pkg;

    localparam int unsigned WIDTH_DEFAULT  = 8;
    localparam int unsigned WIDTH_MIN      = 1;
    localparam int unsigned WIDTH_MAX      = 1024;

    localparam int unsigned STAGES_DEFAULT = 1;
    localparam int unsigned STAGES_MIN     = 1;
    localparam int unsigned STAGES_MAX     = 64;

endpackage

// File: rtl/flopr_stage.sv
// One WIDTH-bit register with synchronous active-low reset to RESET_VAL.
module flopr_stage
    import flopr_pkg::*;
#(
    parameter int unsigned      WIDTH     = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/flopr.sv
// Parameterised pipeline of STAGES registers; q is the last stage, reset loads every stage.
module flopr
    import flopr_pkg::*;
#(
    parameter int unsigned      WIDTH     = WIDTH_DEFAULT,
    parameter int unsigned      STAGES    = STAGES_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $fatal(1, "flopr: WIDTH out of range");
    end
    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $fatal(1, "flopr: STAGES out of range");
    end

    // chain[0] is the input, chain[k+1] is the output of stage k
    logic [WIDTH-1:0] chain [STAGES+1];

    assign chain[0] = d;

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        flopr_stage #(
            .WIDTH    (WIDTH),
            .RESET_VAL(RESET_VAL)
        ) u_stage (
            .clk  (clk),
            .reset(reset),
            .d    (chain[k]),
            .q    (chain[k+1])
        );
    end

    assign q = chain[STAGES];

    a_reset_val: assert property (@(posedge clk) !reset |=> (q == RESET_VAL));

    if (STAGES == 1) begin : g_single_chk
        a_past_d: assert property (@(posedge clk) reset |=> (q == $past(d)));
    end

endmodule

// File: tb/tb_flopr.sv
// Directed and random checks of flopr in 1-, 2- and 3-stage builds against an edge-history model.
module tb_flopr;

    logic       clk;
    logic       reset;
    logic [7:0] d;
    logic [7:0] q1, q2, q3;

    int compared;
    int mismatched;

    // per-edge record of the inputs the DUTs sampled
    logic [7:0] hd [$];
    logic       hr [$];

    flopr #(.WIDTH(8), .STAGES(1)) dut_s1 (
        .clk(clk), .reset(reset), .d(d), .q(q1)
    );

    flopr #(.WIDTH(8), .STAGES(2), .RESET_VAL(8'h5A)) dut_s2 (
        .clk(clk), .reset(reset), .d(d), .q(q2)
    );

    flopr #(.WIDTH(8), .STAGES(3)) dut_s3 (
        .clk(clk), .reset(reset), .d(d), .q(q3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // After the latest edge: reset seen in the last s edges -> rv, else d from s edges back
    function automatic logic [7:0] model(input int s, input logic [7:0] rv);
        int n;
        n = hr.size();
        if (n < s) return rv;
        for (int k = n - s; k < n; k++) begin
            if (!hr[k]) return rv;
        end
        return hd[n - s];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%02h expected=%02h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("q_s1", q1, model(1, 8'h00));
        chk("q_s2_rv5a", q2, model(2, 8'h5A));
        chk("q_s3", q3, model(3, 8'h00));
    endtask

    task automatic step(input logic r, input logic [7:0] dv);
        reset = r;
        d     = dv;
        @(posedge clk);
        hr.push_back(r);
        hd.push_back(dv);
        #1;
        check_all();
    endtask

    initial begin
        logic [7:0] s1, s2, s3;
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        d          = 8'h00;

        // reset with d = 00
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk("reset_q_s1", q1, 8'h00);
        chk("reset_q_s2", q2, 8'h5A);

        // basic pattern
        step(1'b1, 8'hAA);
        chk("aa_q_s1", q1, 8'hAA);
        step(1'b1, 8'h55);
        chk("55_q_s1", q1, 8'h55);
        step(1'b1, 8'hFF);
        chk("ff_q_s1", q1, 8'hFF);

        // reset wins over d, then d appears one edge after release
        step(1'b0, 8'h12);
        chk("rst_wins_q_s1", q1, 8'h00);
        step(1'b1, 8'h12);
        chk("release_q_s1", q1, 8'h12);

        // three-stage latency
        step(1'b1, 8'h01);
        step(1'b1, 8'h02);
        step(1'b1, 8'h03);
        chk("lat3_01", q3, 8'h01);
        step(1'b1, 8'h00);
        chk("lat3_02", q3, 8'h02);
        step(1'b1, 8'h00);
        chk("lat3_03", q3, 8'h03);

        // flush of in-flight data
        step(1'b1, 8'hA1);
        step(1'b1, 8'hA2);
        step(1'b0, 8'hA3);
        chk("flush_q_s3", q3, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h00);
            compared++;
            assert (q3 !== 8'hA1 && q3 !== 8'hA2) else begin
                mismatched++;
                $error("FAIL inflight_leak observed=%02h expected=not_a1_a2", q3);
            end
        end

        // reset glitch between edges has no effect
        step(1'b1, 8'h3C);
        step(1'b1, 8'hC3);
        s1 = q1; s2 = q2; s3 = q3;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("glitch_q_s1", q1, s1);
        chk("glitch_q_s2", q2, s2);
        chk("glitch_q_s3", q3, s3);
        check_all();
        step(1'b1, 8'h77);

        // RESET_VAL 5A visible after reset
        step(1'b0, 8'hEE);
        chk("rv5a_q_s2", q2, 8'h5A);

        // random traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(15) != 0) ? 1'b1 : 1'b0, 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
